// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/writeback
// and drives every datapath select and write enable from the current state.
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             iord,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             memto_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_control,
    output logic [1:0]       pc_src,
    output logic             pc_en,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t cur_state;
    state_t nxt_state;

    logic funct_ok;
    logic decode_bad;
    logic retire;

    logic mem_write_c;
    logic ir_write_c;
    logic reg_write_c;
    logic pc_en_c;

    assign funct_ok = (funct == F_ADD) || (funct == F_SUB) ||
                      (funct == F_AND) || (funct == F_OR)  ||
                      (funct == F_SLT);

    // Decode-time legality: anything that DECODE sends straight back to FETCH
    always_comb begin
        decode_bad = 1'b0;
        if (cur_state == S_DECODE) begin
            unique case (opcode)
                OP_RTYPE: decode_bad = !funct_ok;
                OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: decode_bad = 1'b0;
                default:  decode_bad = 1'b1;
            endcase
        end
    end

    // An instruction retires on its final transition back into FETCH
    assign retire = (cur_state == S_MEMWB)  ||
                    (cur_state == S_MEMWR && mem_ready) ||
                    (cur_state == S_ALUWB)  ||
                    (cur_state == S_BRANCH) ||
                    (cur_state == S_ADDIWB) ||
                    (cur_state == S_JUMP);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cur_state <= S_FETCH;
        else          cur_state <= nxt_state;
    end

    // Illegal-instruction pulse and retired-instruction counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_op  <= 1'b0;
            instr_count <= '0;
        end else begin
            illegal_op <= decode_bad;
            if (retire) instr_count <= instr_count + 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        nxt_state = S_FETCH;
        unique case (cur_state)
            S_FETCH:  nxt_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (opcode)
                    OP_RTYPE: nxt_state = funct_ok ? S_EXEC : S_FETCH;
                    OP_LW,
                    OP_SW:    nxt_state = S_MEMADR;
                    OP_BEQ:   nxt_state = S_BRANCH;
                    OP_ADDI:  nxt_state = S_ADDIEX;
                    OP_J:     nxt_state = S_JUMP;
                    default:  nxt_state = S_FETCH;
                endcase
            end
            S_MEMADR: nxt_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  nxt_state = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  nxt_state = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   nxt_state = S_ALUWB;
            S_ADDIEX: nxt_state = S_ADDIWB;
            default:  nxt_state = S_FETCH;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        iord        = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        reg_dst     = 1'b0;
        memto_reg   = 1'b0;
        reg_write_c = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        pc_src      = 2'b00;
        pc_en_c     = 1'b0;
        unique case (cur_state)
            S_FETCH: begin
                alu_src_b  = 2'b01;
                ir_write_c = mem_ready;
                pc_en_c    = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memto_reg   = 1'b1;
                reg_write_c = 1'b1;
            end
            S_MEMWR: begin
                iord        = 1'b1;
                mem_write_c = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                unique case (funct)
                    F_SUB:   alu_control = ALU_SUB;
                    F_AND:   alu_control = ALU_AND;
                    F_OR:    alu_control = ALU_OR;
                    F_SLT:   alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            S_ALUWB: begin
                reg_dst     = 1'b1;
                reg_write_c = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = 2'b01;
                pc_en_c     = zero;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: reg_write_c = 1'b1;
            S_JUMP: begin
                pc_src  = 2'b10;
                pc_en_c = 1'b1;
            end
            default: begin
                alu_control = ALU_ADD;
            end
        endcase
    end

    // Enables are blocked combinationally so nothing writes while reset is low
    assign mem_write = mem_write_c & reset_n;
    assign ir_write  = ir_write_c  & reset_n;
    assign reg_write = reg_write_c & reset_n;
    assign pc_en     = pc_en_c     & reset_n;
    assign state     = cur_state;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- FSM control unit for a multicycle MIPS datapath: one shared ALU, one unified instruction/data memory, and the existing register file and ALU encodings.
- Sequences each instruction through fetch, decode, execute, memory and writeback states. Drives every datapath mux select and write enable.
- Stalls on a memory-ready handshake, flags illegal instructions, and counts retired instructions.
- Supports R-type (add, sub, and, or, slt), lw, sw, beq, addi and j.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- opcode  input  6  instr[31:26], taken from the instruction register.
- funct  input  6  instr[5:0], taken from the instruction register.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current access this cycle.
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  output  1  memory write enable.
- ir_write  output  1  instruction register load.
- reg_dst  output  1  register write address select: 0 = rt, 1 = rd.
- memto_reg  output  1  register write data select: 0 = ALUOut, 1 = memory data.
- reg_write  output  1  register file write enable.
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = register A.
- alu_src_b  output  2  ALU B select: 00 = register B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_control  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- pc_src  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- pc_en  output  1  PC load enable.
- illegal_op  output  1  one-cycle pulse on an unsupported instruction.
- state  output  4  current state, for debug.
- instr_count  output  CNT_W  number of retired instructions.

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- Outputs are Moore-decoded from state, with two exceptions: ir_write/pc_en in FETCH depend on mem_ready, and pc_en in BRANCH depends on zero.
- Defaults in every state: all enables 0, all selects 0, alu_control 010.
- Reset:
  - While reset_n = 0: state = FETCH, instr_count = 0, illegal_op = 0, and all enables (mem_write, ir_write, reg_write, pc_en) are forced to 0.
  - Reset asserted mid-instruction aborts that instruction immediately. No write completes after reset_n falls.
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, add, pc_src=00.
  - ir_write = pc_en = mem_ready.
  - Stay in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.
- DECODE: alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). Next state by opcode:
  - 000000 with a supported funct → EXEC.
  - 100011 or 101011 → MEMADR.
  - 000100 → BRANCH.
  - 001000 → ADDIEX.
  - 000010 → JUMP.
  - Any other opcode, or 000000 with funct not in {100000, 100010, 100100, 100101, 101010} → FETCH, and illegal_op is registered high for exactly the next cycle.
- MEMADR: alu_src_a=1, alu_src_b=10, add. Go to MEMRD if opcode = 100011, else MEMWR.
- MEMRD: iord=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: reg_dst=0, memto_reg=1, reg_write=1. Go to FETCH.
- MEMWR: iord=1, mem_write=1, held until mem_ready. On the mem_ready cycle go to FETCH; mem_write drops the following cycle.
- EXEC: alu_src_a=1, alu_src_b=00, alu_control from funct:
  - add → 010, sub → 110, and → 000, or → 001, slt → 111.
  - Go to ALUWB.
- ALUWB: reg_dst=1, memto_reg=0, reg_write=1. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_en = zero. Go to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, add. Go to ADDIWB.
- ADDIWB: reg_dst=0, memto_reg=0, reg_write=1. Go to FETCH.
- JUMP: pc_src=10, pc_en=1. Go to FETCH.
- instr_count:
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWR (on the mem_ready cycle), ALUWB, BRANCH, ADDIWB or JUMP.
  - Illegal instructions do not count.
  - Wraps modulo 2^CNT_W.
- Latency in cycles with mem_ready tied to 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each cycle that mem_ready is low adds one cycle.
- opcode and funct are sampled only in DECODE, MEMADR and EXEC; their values in other states are don't-care.

Test Plan:
- Reset held low 3 cycles with mem_ready=1 → state=0, pc_en=0, ir_write=0, reg_write=0, mem_write=0, instr_count=0. Release reset → first cycle has ir_write=1 and pc_en=1.
- add (opcode 000000, funct 100000), mem_ready=1 → states 0,1,6,7,0; alu_control=010 in EXEC; reg_write=1 and reg_dst=1 only in ALUWB; instr_count 0→1.
- lw (100011) with mem_ready low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0; memto_reg=1 and reg_write=1 in MEMWB; 7 cycles total.
- sw (101011) with mem_ready low for 1 cycle → mem_write=1 for 2 consecutive cycles with iord=1; reg_write stays 0 throughout.
- beq (000100) with zero=1, then again with zero=0 → pc_en=1 with pc_src=01 in BRANCH for the first, pc_en=0 for the second; instr_count +2.
- Opcode 111111, then opcode 000000 with funct 000111 → each goes DECODE→FETCH with illegal_op high for one cycle; instr_count unchanged. Separately, reset_n pulsed low during ALUWB → reg_write drops immediately and state=0.
